acc_datapath_stk: RTL

Parametrised next-generation accumulator datapath for the teaching CPU. It holds the PC, the accumulator, the general register file and the ALU, as the current 8-bit datapath does. It adds registered Z/C flags, a conditional branch on zero, and a hardware return-address stack for CALL/RET. The control FSM drives it; program memory is addressed by Pc, and LEDs mirror the accumulator.

---
 rtl/acc_datapath_stk.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/acc_datapath_stk.sv
// Accumulator datapath for the teaching CPU: PC, accumulator with Z/C flags,
// general register file, combinational ALU and a return-address stack for
// CALL/RET. The external control FSM sequences all enables.
module acc_datapath_stk #(
    parameter int N       = 8,
    parameter int PC_W    = 5,
    parameter int REG_AW  = 4,
    parameter int REG_CNT = 11,
    parameter int STK_D   = 4
) (
    input  logic                           Clock,
    input  logic                           nReset,
    input  logic [N-1:0]                   MemData,
    input  logic [N-1:0]                   Switches,
    input  logic                           RegWe,
    input  logic                           ImmSel,
    input  logic                           Op1Sel,
    input  logic                           WDataSel,
    input  logic                           AccWe,
    input  logic                           PcWe,
    input  logic [2:0]                     PcSel,
    input  logic [2:0]                     AluOp,
    output logic [PC_W-1:0]                Pc,
    output logic [N-1:0]                   LEDs,
    output logic                           ZFlag,
    output logic                           CFlag,
    output logic                           StkErr,
    output logic [$clog2(STK_D+1)-1:0]     StkDepth
);

    localparam int SD_W = $clog2(STK_D + 1);
    localparam int SK_W = (STK_D > 1) ? $clog2(STK_D) : 1;
    localparam int RI_W = (REG_CNT > 1) ? $clog2(REG_CNT) : 1;

    localparam logic [2:0] SEL_JMP  = 3'd1;
    localparam logic [2:0] SEL_BZ   = 3'd2;
    localparam logic [2:0] SEL_CALL = 3'd3;
    localparam logic [2:0] SEL_RET  = 3'd4;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_XOR   = 3'd4;
    localparam logic [2:0] OP_PASSA = 3'd5;
    localparam logic [2:0] OP_PASSB = 3'd6;

    logic [N-1:0]      acc;
    logic              zflag;
    logic              cflag;
    logic [N-1:0]      regs [REG_CNT];
    logic [REG_AW-1:0] raddr;
    logic              addr_ok;
    logic [N-1:0]      rdata;
    logic [N-1:0]      imm;
    logic [N-1:0]      opa;
    logic [N-1:0]      q;
    logic              carry;

    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   target;
    logic [PC_W-1:0]   stk [STK_D];
    logic [SD_W-1:0]   depth;
    logic [SD_W-1:0]   depth_dec;
    logic              stk_full;
    logic              stk_empty;
    logic              stkerr;

    // Upper half of the instruction word is the opcode, decoded by the FSM only.
    logic unused_opcode;
    assign unused_opcode = ^MemData[N-1:N/2];

    // Returns {carry, result}; SUB carry is the borrow out of B - A.
    function automatic logic [N:0] alu(input logic [2:0] op,
                                       input logic [N-1:0] a,
                                       input logic [N-1:0] b);
        case (op)
            OP_ADD:   alu = {1'b0, b} + {1'b0, a};
            OP_SUB:   alu = {1'b0, b} - {1'b0, a};
            OP_AND:   alu = {1'b0, b & a};
            OP_OR:    alu = {1'b0, b | a};
            OP_XOR:   alu = {1'b0, b ^ a};
            OP_PASSA: alu = {1'b0, a};
            OP_PASSB: alu = {1'b0, b};
            default:  alu = {b[N-1], b[N-2:0], 1'b0};
        endcase
    endfunction

    assign raddr   = MemData[REG_AW-1:0];
    assign addr_ok = int'(raddr) < REG_CNT;
    assign rdata   = addr_ok ? regs[raddr[RI_W-1:0]] : '0;
    assign imm     = ImmSel ? {MemData[N/2-1:0], {(N/2){1'b0}}}
                            : {{(N/2){1'b0}}, MemData[N/2-1:0]};
    assign opa     = Op1Sel ? imm : rdata;
    assign {carry, q} = alu(AluOp, opa, acc);

    assign pc_inc    = pc + PC_W'(1);
    assign target    = q[PC_W-1:0];
    assign stk_full  = int'(depth) >= STK_D;
    assign stk_empty = (depth == '0);
    assign depth_dec = depth - SD_W'(1);

    // Accumulator and flags load from the ALU result on AccWe.
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            acc   <= '0;
            zflag <= 1'b0;
            cflag <= 1'b0;
        end else if (AccWe) begin
            acc   <= q;
            zflag <= (q == '0);
            cflag <= carry;
        end
    end

    // Register file write; old Acc (not Q) is the non-switch source, and
    // addresses beyond the implemented registers are dropped.
    always_ff @(posedge Clock) begin
        if (RegWe && addr_ok)
            regs[raddr[RI_W-1:0]] <= WDataSel ? Switches : acc;
    end

    // Program counter, stack pointer and sticky error; BZ uses the flag held
    // before this edge.
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            pc     <= '0;
            depth  <= '0;
            stkerr <= 1'b0;
        end else if (PcWe) begin
            case (PcSel)
                SEL_JMP: pc <= target;
                SEL_BZ:  pc <= zflag ? target : pc_inc;
                SEL_CALL: begin
                    if (!stk_full) begin
                        pc    <= target;
                        depth <= depth + SD_W'(1);
                    end else begin
                        pc     <= pc_inc;
                        stkerr <= 1'b1;
                    end
                end
                SEL_RET: begin
                    if (!stk_empty) begin
                        pc    <= stk[depth_dec[SK_W-1:0]];
                        depth <= depth_dec;
                    end else begin
                        pc     <= pc_inc;
                        stkerr <= 1'b1;
                    end
                end
                default: pc <= pc_inc;
            endcase
        end
    end

    // Return-address storage; a successful CALL writes the slot at the pointer.
    always_ff @(posedge Clock) begin
        if (nReset && PcWe && (PcSel == SEL_CALL) && !stk_full)
            stk[depth[SK_W-1:0]] <= pc_inc;
    end

    assign Pc       = pc;
    assign LEDs     = acc;
    assign ZFlag    = zflag;
    assign CFlag    = cflag;
    assign StkErr   = stkerr;
    assign StkDepth = depth;

endmodule
